keypad_scanner: RTL and testbench

//   Scans the 4x4 PmodKYPD on JA: drives columns JA[3:0], samples rows JA[7:4], debounces, emits one-cycle key strobe.

---
 rtl/keypad_pkg.sv | 22 ++
 rtl/keypad_code_lut.sv | 36 +++
 rtl/keypad_scanner.sv | 136 +++++++++++++
 tb/tb_keypad_scanner.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, column
// drive patterns and the idle row pattern.
package keypad_pkg;

   typedef enum logic [1:0] {
      StScan,
      StDebounce,
      StPressed
   } state_e;

   localparam logic [3:0] Col0  = 4'b0111;
   localparam logic [3:0] Col1  = 4'b1011;
   localparam logic [3:0] Col2  = 4'b1101;
   localparam logic [3:0] Col3  = 4'b1110;
   localparam logic [3:0] NoKey = 4'b1111;

   // Rotating right walks the single low bit 0111 -> 1011 -> 1101 -> 1110 -> 0111.
   function automatic logic [3:0] next_col(input logic [3:0] c);
      return {c[0], c[3:1]};
   endfunction

endpackage

// File: rtl/keypad_code_lut.sv
// Combinational decode of a one-cold column drive and a row pattern into the
// keypad hex code; valid_o is low for no key or multiple keys in the column.
module keypad_code_lut
   import keypad_pkg::*;
(
   input  logic [3:0] col_i,
   input  logic [3:0] row_i,
   output logic [3:0] code_o,
   output logic       valid_o
);

   always_comb begin
      code_o  = 4'h0;
      valid_o = 1'b1;
      case ({col_i, row_i})
         {Col0, 4'b0111}: code_o = 4'h1;
         {Col0, 4'b1011}: code_o = 4'h4;
         {Col0, 4'b1101}: code_o = 4'h7;
         {Col0, 4'b1110}: code_o = 4'h0;
         {Col1, 4'b0111}: code_o = 4'h2;
         {Col1, 4'b1011}: code_o = 4'h5;
         {Col1, 4'b1101}: code_o = 4'h8;
         {Col1, 4'b1110}: code_o = 4'hF;
         {Col2, 4'b0111}: code_o = 4'h3;
         {Col2, 4'b1011}: code_o = 4'h6;
         {Col2, 4'b1101}: code_o = 4'h9;
         {Col2, 4'b1110}: code_o = 4'hE;
         {Col3, 4'b0111}: code_o = 4'hA;
         {Col3, 4'b1011}: code_o = 4'hB;
         {Col3, 4'b1101}: code_o = 4'hC;
         {Col3, 4'b1110}: code_o = 4'hD;
         default:         valid_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/keypad_scanner.sv
// PmodKYPD scanner: walks the columns, samples synchronised rows once per dwell,
// debounces press and release, and emits a one-cycle key strobe with its code.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES  = 100000,
   parameter int unsigned DEBOUNCE_COUNT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int unsigned DwellW = $clog2(SETTLE_CYCLES);
   localparam int unsigned CntW   = $clog2(DEBOUNCE_COUNT + 1);
   localparam logic [DwellW-1:0] DwellLast = DwellW'(SETTLE_CYCLES - 1);
   localparam logic [CntW-1:0]   CntDone   = CntW'(DEBOUNCE_COUNT);

   logic [3:0]        row_meta_q, row_sync_q;
   logic [DwellW-1:0] dwell_q, dwell_d;
   state_e            state_q, state_d;
   logic [3:0]        col_q, col_d;
   logic [3:0]        pat_q, pat_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [3:0]        key_code_q, key_code_d;
   logic              key_valid_q, key_valid_d;
   logic              key_held_q, key_held_d;

   logic              sample;
   logic [CntW-1:0]   cnt_inc;
   logic [3:0]        lut_code;
   logic              lut_valid;

   keypad_code_lut u_lut (
      .col_i   (col_q),
      .row_i   (row_sync_q),
      .code_o  (lut_code),
      .valid_o (lut_valid)
   );

   assign sample  = (dwell_q == DwellLast);
   assign cnt_inc = cnt_q + CntW'(1);
   assign dwell_d = sample ? '0 : dwell_q + DwellW'(1);

   // cnt_q counts matching press samples in StDebounce and empty samples in StPressed.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      pat_d       = pat_q;
      cnt_d       = cnt_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      if (sample) begin
         unique case (state_q)
            StScan: begin
               if (lut_valid) begin
                  pat_d   = row_sync_q;
                  cnt_d   = CntW'(1);
                  state_d = StDebounce;
               end else begin
                  col_d = next_col(col_q);
               end
            end
            StDebounce: begin
               if (row_sync_q == pat_q) begin
                  if (cnt_inc == CntDone) begin
                     key_valid_d = 1'b1;
                     key_code_d  = lut_code;
                     key_held_d  = 1'b1;
                     cnt_d       = '0;
                     state_d     = StPressed;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  cnt_d   = '0;
                  state_d = StScan;
                  col_d   = next_col(col_q);
               end
            end
            StPressed: begin
               if (row_sync_q == NoKey) begin
                  if (cnt_inc == CntDone) begin
                     key_held_d = 1'b0;
                     cnt_d      = '0;
                     state_d    = StScan;
                     col_d      = next_col(col_q);
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            default: state_d = StScan;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_meta_q  <= NoKey;
         row_sync_q  <= NoKey;
         dwell_q     <= '0;
         state_q     <= StScan;
         col_q       <= Col0;
         pat_q       <= NoKey;
         cnt_q       <= '0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         row_meta_q  <= row;
         row_sync_q  <= row_meta_q;
         dwell_q     <= dwell_d;
         state_q     <= state_d;
         col_q       <= col_d;
         pat_q       <= pat_d;
         cnt_q       <= cnt_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   assign col       = col_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a switch-matrix keypad model drives the rows from
// the column drive; directed and random presses are checked against expected key events.
module tb_keypad_scanner;

   localparam int unsigned S = 4;
   localparam int unsigned D = 3;
   localparam int Bound = (3 + D) * S + 3 + 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  row, col, key_code;
   logic        key_valid, key_held;
   logic [15:0] pressed;

   int          n_vec = 0;
   int          n_err = 0;
   int          pulses = 0;
   int          wide = 0;
   logic [3:0]  last_code = 4'h0;
   logic        prev_valid = 1'b0;
   logic [3:0]  colseq [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

   always #5 clk = ~clk;

   keypad_scanner #(
      .SETTLE_CYCLES  (S),
      .DEBOUNCE_COUNT (D)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .row       (row),
      .col       (col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   // Physical keypad face, read left-to-right, top-to-bottom.
   function automatic logic [3:0] key_at(input int ci, input int ri);
      logic [63:0] layout;
      layout = 64'h123A_456B_789C_0FED;
      return layout[63 - 4 * (ri * 4 + ci) -: 4];
   endfunction

   function automatic int col_of(input logic [3:0] k);
      int c;
      c = 0;
      for (int ci = 0; ci < 4; ci++)
         for (int ri = 0; ri < 4; ri++)
            if (key_at(ci, ri) == k) c = ci;
      return c;
   endfunction

   // Column ci is driven low on col[3-ci]; a closed switch pulls row[3-ri] low.
   always_comb begin
      row = 4'hF;
      for (int ci = 0; ci < 4; ci++)
         for (int ri = 0; ri < 4; ri++)
            if (pressed[key_at(ci, ri)] && !col[3-ci]) row[3-ri] = 1'b0;
   end

   always @(negedge clk) begin
      if (key_valid) begin
         pulses    <= pulses + 1;
         last_code <= key_code;
         if (prev_valid) wide <= wide + 1;
      end
      prev_valid <= key_valid;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_pulse(input int p0, output int lat);
      lat = 0;
      while (pulses == p0 && lat < Bound + 2) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic wait_release();
      int n;
      n = 0;
      while (key_held && n < Bound) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_col(input logic [3:0] c);
      int n;
      n = 0;
      while (col !== c && n < 8 * S) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic press_accept(input logic [3:0] k, input int hold);
      int p0, lat;
      p0 = pulses;
      pressed = 16'(1) << k;
      wait_pulse(p0, lat);
      check("press_pulse", pulses - p0, 1);
      check("press_latency", lat <= Bound, 1);
      check("press_code", last_code, k);
      check("held_on", key_held, 1);
      cyc(hold);
      check("no_repeat", pulses - p0, 1);
      check("held_while_down", key_held, 1);
      pressed = '0;
      wait_release();
      check("held_off", key_held, 0);
      check("resume_col", col, colseq[(col_of(k) + 1) % 4]);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int p0, lat;
      logic [3:0] k;

      pressed = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_col", col, 4'b0111);
      check("reset_valid", key_valid, 0);
      check("reset_held", key_held, 0);
      check("reset_code", key_code, 0);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check("col_step", col, colseq[(i / S) % 4]);
         @(negedge clk);
      end

      press_accept(4'h5, 30);

      // Bounce on 'D': each closure spans at most two samples.
      p0 = pulses;
      repeat (2) begin
         pressed = 16'(1) << 4'hD;
         cyc(6);
         pressed = '0;
         cyc(6);
      end
      check("bounce_quiet", pulses - p0, 0);
      press_accept(4'hD, 20);

      // Hold 'A', then add '3' in another column.
      p0 = pulses;
      pressed = 16'(1) << 4'hA;
      wait_pulse(p0, lat);
      check("a_pulse", pulses - p0, 1);
      check("a_code", last_code, 4'hA);
      cyc(50 * S);
      pressed = pressed | (16'(1) << 4'h3);
      cyc(25 * S);
      check("a_hold_single", pulses - p0, 1);
      check("a_held", key_held, 1);
      pressed = 16'(1) << 4'h3;
      wait_release();
      check("a_released", key_held, 0);
      check("three_blocked", pulses - p0, 1);
      wait_pulse(p0 + 1, lat);
      check("three_pulse", pulses - p0, 2);
      check("three_code", last_code, 4'h3);
      pressed = '0;
      wait_release();
      check("three_released", key_held, 0);

      // Two keys in one column give row 0011.
      p0 = pulses;
      pressed = (16'(1) << 4'h1) | (16'(1) << 4'h4);
      cyc(50 * S);
      check("multi_quiet", pulses - p0, 0);
      check("multi_not_held", key_held, 0);
      pressed = '0;
      cyc(2 * S);

      // Reset while '9' is being debounced.
      wait_col(4'b1110);
      p0 = pulses;
      pressed = 16'(1) << 4'h9;
      wait_col(4'b1101);
      cyc(5);
      check("nine_debouncing", col, 4'b1101);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_mid_col", col, 4'b0111);
      check("rst_mid_valid", key_valid, 0);
      check("rst_mid_held", key_held, 0);
      check("rst_mid_code", key_code, 0);
      @(negedge clk);
      rst = 1'b0;
      pressed = '0;
      cyc(10 * S);
      check("rst_mid_no_pulse", pulses - p0, 0);

      for (int i = 0; i < 6; i++) begin
         k = 4'($urandom_range(15, 0));
         press_accept(k, int'($urandom_range(60, 10)));
         cyc(int'($urandom_range(20, 0)));
      end

      cyc(2);
      check("pulse_width", wide, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
